// File: rtl/elbeth_id_operand_stage.sv
// Decode-side operand stage of the 5-stage RV32I pipeline.
// Drives the two register-file read ports and bypasses each source from EX, MEM or WB
// (highest priority first; x0 is always 0). On load-use it inserts one bubble and holds
// PC and IF/ID. It then captures the instruction and its operands into the ID/EX register.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_*                           IF/ID instruction fields (valid, pc, rs1/rs2/rd, flags, imm)
//   id_rs1_addr/id_rs2_addr        register-file read addresses (combinational)
//   id_rs1_data/id_rs2_data        register-file read data
//   ex_result                      ALU result of the instruction held in ex_*
//   mem_rd_addr/we, mem_result     MEM-stage writeback candidate
//   wb_rd_addr/we, wb_rd_data      WB write port (same nets as the register-file write)
//   ex_flush                       kill the younger instruction (taken branch/jump in EX)
//   id_stall                       hold PC and IF/ID this cycle
//   ex_*                           ID/EX pipeline register outputs
module elbeth_id_operand_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [4:0]      if_rs1_addr,
  input  logic [4:0]      if_rs2_addr,
  input  logic            if_uses_rs1,
  input  logic            if_uses_rs2,
  input  logic [4:0]      if_rd_addr,
  input  logic            if_rd_we,
  input  logic            if_is_load,
  input  logic [XLEN-1:0] if_imm,
  output logic [4:0]      id_rs1_addr,
  output logic [4:0]      id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_rd_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_rd_we,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            ex_flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rd_we,
  output logic            ex_is_load
);

  logic            ex_valid_q, ex_valid_d;
  logic            ex_rd_we_q, ex_rd_we_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic [31:0]     ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0] ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_addr_q, ex_rd_addr_d;

  logic [1:0][4:0]      src_addr;
  logic [1:0][XLEN-1:0] rf_data;
  logic [1:0][XLEN-1:0] fwd_data;
  logic                 ex_fwd_ok;
  logic                 lu;

  assign id_rs1_addr = if_rs1_addr;
  assign id_rs2_addr = if_rs2_addr;

  assign src_addr = {if_rs2_addr, if_rs1_addr};
  assign rf_data  = {id_rs2_data, id_rs1_data};

  // A load in EX has no data yet; its consumer is caught by the load-use stall instead.
  assign ex_fwd_ok = ex_valid_q & ex_rd_we_q & ~ex_is_load_q;

  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < 2; i++) begin
      if (src_addr[i] == 5'd0) begin
        fwd_data[i] = '0;
      end else if (ex_fwd_ok && (ex_rd_addr_q == src_addr[i])) begin
        fwd_data[i] = ex_result;
      end else if (mem_rd_we && (mem_rd_addr == src_addr[i])) begin
        fwd_data[i] = mem_result;
      end else if (wb_rd_we && (wb_rd_addr == src_addr[i])) begin
        // Register file writes on the same edge, so its read data is still stale.
        fwd_data[i] = wb_rd_data;
      end else begin
        fwd_data[i] = rf_data[i];
      end
    end
  end

  always_comb begin
    lu = if_valid & ex_valid_q & ex_is_load_q & ex_rd_we_q & (ex_rd_addr_q != 5'd0) &
         ((if_uses_rs1 & (if_rs1_addr == ex_rd_addr_q)) |
          (if_uses_rs2 & (if_rs2_addr == ex_rd_addr_q)));
    id_stall = lu & ~ex_flush;
  end

  // Bubbles clear only the control bits; data fields keep their previous contents.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rd_we_d   = ex_rd_we_q;
    ex_is_load_d = ex_is_load_q;
    ex_pc_d      = ex_pc_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_addr_d = ex_rd_addr_q;
    if (ex_flush || lu) begin
      ex_valid_d   = 1'b0;
      ex_rd_we_d   = 1'b0;
      ex_is_load_d = 1'b0;
    end else begin
      ex_valid_d   = if_valid;
      ex_rd_we_d   = if_rd_we;
      ex_is_load_d = if_is_load;
      ex_pc_d      = if_pc;
      ex_rs1_val_d = fwd_data[0];
      ex_rs2_val_d = fwd_data[1];
      ex_imm_d     = if_imm;
      ex_rd_addr_d = if_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_rd_we_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_pc_q      <= RESET_PC;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_imm_q     <= '0;
      ex_rd_addr_q <= 5'd0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rd_we_q   <= ex_rd_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_addr_q <= ex_rd_addr_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd_addr = ex_rd_addr_q;
  assign ex_rd_we   = ex_rd_we_q;
  assign ex_is_load = ex_is_load_q;

endmodule
